msg_ngram_streamer: RTL
=======================

Name: msg_ngram_streamer

Overview:
- Upstream stage of the HDC classifier datapath.
- Takes a packed character message, as loaded by the test harness (msg bus plus length), and streams it as a sequence of sliding character n-grams, one per valid/ready beat.
- The downstream hypervector encoder consumes one n-gram per transfer and bundles it into the message hypervector.
- first/last markers let the encoder delimit one message.

Parameters:
- MAX_LENGTH, 160, maximum characters per message.
- CHAR_W, 8, bits per character.
- NGRAM, 3, characters per emitted gram (legal range 1..MAX_LENGTH).
- LEN_W, 8, width of the length input and internal index.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request to begin streaming; sampled only in IDLE.
- msg  input  MAX_LENGTH*CHAR_W  packed message; char 0 at msg[MAX_LENGTH*CHAR_W-1 -: CHAR_W], char i at msg[(MAX_LENGTH-1-i)*CHAR_W +: CHAR_W].
- length  input  LEN_W  number of valid characters in msg.
- busy  output  1  high while a message is being processed.
- gram_valid  output  1  gram_data holds a valid n-gram.
- gram_ready  input  1  downstream accepts the gram this cycle.
- gram_data  output  NGRAM*CHAR_W  chars k..k+NGRAM-1; char k in the MSBs.
- gram_first  output  1  qualifies gram_data: this is gram k=0.
- gram_last  output  1  qualifies gram_data: this is the final gram.
- done  output  1  one-cycle pulse at end of a message (normal or error).
- err_len  output  1  one-cycle pulse, coincident with done, for an illegal length.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, gram_valid, gram_first, gram_last, done, err_len = 0; gram_data = 0; index = 0; snapshot registers cleared.
- States: IDLE, STREAM, FINISH.
- IDLE + start=1:
  - Snapshot msg and length into internal registers. Later changes to msg or length do not affect the current message.
  - Legal length (NGRAM <= length <= MAX_LENGTH): go to STREAM with index k=0. busy=1 and gram_valid=1 from the next cycle; gram 0 is presented one cycle after start.
  - Illegal length: go to FINISH with an error flag set; no grams are emitted.
- STREAM:
  - gram_data, gram_first and gram_last are registered and held stable while gram_valid=1 and gram_ready=0.
  - A transfer is gram_valid & gram_ready. On a transfer with k < length-NGRAM: k increments and the next gram is presented the following cycle. Zero-bubble throughput: one gram per cycle under continuous ready.
  - Transfer with k = length-NGRAM (gram_last=1): gram_valid drops the next cycle; go to FINISH.
  - Gram count is exactly length-NGRAM+1. When length = NGRAM, the single gram has gram_first = gram_last = 1.
- FINISH:
  - done=1 for exactly one cycle; err_len=1 in the same cycle if the error flag is set.
  - busy stays 1 during this cycle; next state is IDLE, where busy=0.
- start is ignored whenever state != IDLE; no queuing.
- gram_ready is ignored when gram_valid=0.
- Index arithmetic is LEN_W bits unsigned. The comparison length < NGRAM must be evaluated without underflow, before computing length-NGRAM.
- Reset asserted mid-message aborts immediately to the reset values above; no done pulse is produced.

Decomposition:
- Shared package hdc_pkg:
  - MAX_LENGTH, CHAR_W, LEN_W constants.
  - State enumeration encodings.
  - Character-extraction index function, char i -> bit offset, reused by the encoder and bench.
- One natural sub-module: msg_char_mux. It is combinational: snapshot plus index in, NGRAM characters out. It isolates the wide mux from the FSM/handshake logic.

Test Plan:
- msg="abcd" (remaining chars 0), length=4, gram_ready tied 1:
  - gram_valid high from start+1 for 2 cycles.
  - gram_data="abc" with first=1, then "bcd" with last=1.
  - done pulse at start+3; err_len=0.
- Same message with gram_ready toggling 1,0,0,1:
  - "bcd" held stable across the stall cycles.
  - Exactly 2 transfers; done one cycle after the last transfer.
- length=3, msg="xyz": single gram "xyz" with first=last=1, then done.
- length=2 and length=200:
  - No gram_valid.
  - done and err_len both pulse at start+1.
  - busy high only for that cycle.
- length=160, all 160 chars distinct, ready=1:
  - 158 grams; last gram = chars 157..159.
  - start pulses asserted mid-stream are ignored; msg changed mid-stream does not alter output.
- Stream with length=10, assert reset=0 after gram 4 is transferred:
  - All outputs 0 asynchronously; no done pulse.
  - After release, a new start with "abcd" reproduces test 1 exactly.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC classifier datapath: message geometry,
// streamer state encoding and the packed-message character addressing helper.
package hdc_pkg;

  localparam int MAX_LENGTH = 160;
  localparam int CHAR_W     = 8;
  localparam int LEN_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Bit offset of the LSB of character idx in a packed message whose
  // character 0 occupies the most significant CHAR_W bits.
  function automatic int unsigned char_lsb(input int unsigned idx,
                                           input int unsigned max_len,
                                           input int unsigned char_w);
    return (max_len - 1 - idx) * char_w;
  endfunction

endpackage

// File: rtl/msg_char_mux.sv
// Combinational window selector: picks NGRAM consecutive characters starting
// at idx out of the message snapshot, first character in the MSBs.
module msg_char_mux #(
  parameter int MAX_LENGTH = hdc_pkg::MAX_LENGTH,
  parameter int CHAR_W     = hdc_pkg::CHAR_W,
  parameter int LEN_W      = hdc_pkg::LEN_W,
  parameter int NGRAM      = 3
) (
  input  logic [MAX_LENGTH*CHAR_W-1:0] snap,
  input  logic [LEN_W-1:0]             idx,
  output logic [NGRAM*CHAR_W-1:0]      gram
);
  import hdc_pkg::*;

  localparam int OFF_W = $clog2(MAX_LENGTH * CHAR_W);

  // Positions past the end of the buffer read as zero so the shifter never
  // addresses outside the snapshot, even on an unused index value.
  for (genvar gi = 0; gi < NGRAM; gi++) begin : g_char
    logic [31:0]      pos;
    logic             in_range;
    logic [OFF_W-1:0] lsb;

    assign pos      = 32'(idx) + 32'(gi);
    assign in_range = (pos < 32'(MAX_LENGTH));
    assign lsb      = in_range ? OFF_W'(char_lsb(pos, MAX_LENGTH, CHAR_W)) : '0;
    assign gram[(NGRAM-1-gi)*CHAR_W +: CHAR_W] = in_range ? snap[lsb +: CHAR_W] : '0;
  end

endmodule

// File: rtl/msg_ngram_streamer.sv
// Streams a snapshotted character message as sliding n-grams over a
// valid/ready interface, with first/last markers and a done/err_len pulse.
module msg_ngram_streamer #(
  parameter int MAX_LENGTH = hdc_pkg::MAX_LENGTH,
  parameter int CHAR_W     = hdc_pkg::CHAR_W,
  parameter int NGRAM      = 3,
  parameter int LEN_W      = hdc_pkg::LEN_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [MAX_LENGTH*CHAR_W-1:0] msg,
  input  logic [LEN_W-1:0]             length,
  output logic                         busy,
  output logic                         gram_valid,
  input  logic                         gram_ready,
  output logic [NGRAM*CHAR_W-1:0]      gram_data,
  output logic                         gram_first,
  output logic                         gram_last,
  output logic                         done,
  output logic                         err_len
);
  import hdc_pkg::*;

  localparam int MSG_W  = MAX_LENGTH * CHAR_W;
  localparam int GRAM_W = NGRAM * CHAR_W;

  state_e              state_q, state_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic                gram_valid_q, gram_valid_d;
  logic                gram_first_q, gram_first_d;
  logic                gram_last_q, gram_last_d;
  logic [GRAM_W-1:0]   gram_data_q, gram_data_d;

  logic                len_legal;
  logic                xfer;
  logic [LEN_W-1:0]    last_idx;
  logic [GRAM_W-1:0]   mux_gram;

  // Both bounds are compared in 32 bits so a short length never wraps
  // before the subtraction below is used.
  assign len_legal = (32'(length) >= 32'(NGRAM)) && (32'(length) <= 32'(MAX_LENGTH));
  assign xfer      = gram_valid_q & gram_ready;
  // Only meaningful for a legal snapshot, which is the only time it is used.
  assign last_idx  = len_q - LEN_W'(NGRAM);

  // The mux looks at the next snapshot/index so the gram register can load
  // the upcoming window on the same edge the index advances.
  msg_char_mux #(
    .MAX_LENGTH (MAX_LENGTH),
    .CHAR_W     (CHAR_W),
    .LEN_W      (LEN_W),
    .NGRAM      (NGRAM)
  ) u_char_mux (
    .snap (msg_d),
    .idx  (idx_d),
    .gram (mux_gram)
  );

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      msg_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      gram_valid_q <= 1'b0;
      gram_first_q <= 1'b0;
      gram_last_q  <= 1'b0;
      gram_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      gram_valid_q <= gram_valid_d;
      gram_first_q <= gram_first_d;
      gram_last_q  <= gram_last_d;
      gram_data_q  <= gram_data_d;
    end
  end

  // Next-state: start only matters in IDLE; the last accepted gram ends STREAM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = len_legal ? ST_STREAM : ST_FINISH;
      ST_STREAM: if (xfer && gram_last_q) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Snapshot capture on start and index advance on every non-final transfer.
  always_comb begin
    msg_d = msg_q;
    len_d = len_q;
    idx_d = idx_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d = msg;
          len_d = length;
          idx_d = '0;
          err_d = !len_legal;
        end
      end
      ST_STREAM: begin
        if (xfer && !gram_last_q) idx_d = idx_q + LEN_W'(1);
      end
      default: ;
    endcase
  end

  // Outputs: registered gram handshake fields plus Moore busy/done/err_len.
  always_comb begin
    gram_valid_d = gram_valid_q;
    gram_first_d = gram_first_q;
    gram_last_d  = gram_last_q;
    gram_data_d  = gram_data_q;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_FINISH);
    err_len      = (state_q == ST_FINISH) && err_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_legal) begin
          gram_valid_d = 1'b1;
          gram_first_d = 1'b1;
          gram_last_d  = (length == LEN_W'(NGRAM));
          gram_data_d  = mux_gram;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (gram_last_q) begin
            gram_valid_d = 1'b0;
            gram_first_d = 1'b0;
            gram_last_d  = 1'b0;
            gram_data_d  = '0;
          end else begin
            gram_first_d = 1'b0;
            gram_last_d  = (idx_d == last_idx);
            gram_data_d  = mux_gram;
          end
        end
      end
      default: ;
    endcase
  end

  assign gram_valid = gram_valid_q;
  assign gram_first = gram_first_q;
  assign gram_last  = gram_last_q;
  assign gram_data  = gram_data_q;

endmodule
